// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman code-length scanner.
package huff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] END_SYM_DEFAULT = 6'b010010;

    // Length field must hold 0..BUS_WIDTH inclusive.
    function automatic int len_w(input int bus_width);
        return $clog2(bus_width) + 1;
    endfunction

endpackage

// File: rtl/huff_len_scan_if.sv
// Input/result handshake bundle for huff_len_scan.
interface huff_len_scan_if #(
    parameter int BUS_WIDTH = 64,
    parameter int LANES     = 4,
    parameter int END_WIDTH = 6
);
    localparam int LEN_W = huff_pkg::len_w(BUS_WIDTH);

    logic [LANES*BUS_WIDTH-1:0] din;
    logic [LANES-1:0]           lane_en;
    logic [END_WIDTH-1:0]       end_sym;
    logic                       in_valid;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*LEN_W-1:0]     len;
    logic [LANES-1:0]           miss;
    logic                       busy;

    modport master (
        output din, lane_en, end_sym, in_valid, out_ready,
        input  in_ready, out_valid, len, miss, busy
    );

    modport slave (
        input  din, lane_en, end_sym, in_valid, out_ready,
        output in_ready, out_valid, len, miss, busy
    );
endinterface

// File: rtl/huff_len_lane.sv
// One scan lane: shifts its word right until the low bits equal the end
// symbol, counting shifts; gives up after all BUS_WIDTH positions.
module huff_len_lane #(
    parameter int BUS_WIDTH = 64,
    parameter int LEN_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en_in,
    input  logic [BUS_WIDTH-1:0] word_in,
    input  logic [BUS_WIDTH-1:0] sym,
    input  logic                 scan,
    output logic                 done_nxt,
    output logic [LEN_W-1:0]     len,
    output logic                 miss
);
    logic [BUS_WIDTH-1:0] sh_q;
    logic [LEN_W-1:0]     cnt_q;
    logic                 done_q;
    logic                 hit;
    logic                 exhausted;

    // Match/exhaustion detect, and done-including-this-cycle for the FSM.
    // A miss is declared one cycle after the last position fails, so it
    // reports with the timing of a match at position BUS_WIDTH.
    always_comb begin
        hit       = (sh_q == sym);
        exhausted = (cnt_q == LEN_W'(BUS_WIDTH));
        done_nxt  = done_q | (scan & (hit | exhausted));
    end

    // Lane register, counter and result latch; done lanes are frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            len    <= '0;
            miss   <= 1'b0;
        end else if (load) begin
            sh_q   <= word_in;
            cnt_q  <= '0;
            done_q <= ~en_in;
            len    <= '0;
            miss   <= 1'b0;
        end else if (scan && !done_q) begin
            if (exhausted) begin
                done_q <= 1'b1;
                len    <= LEN_W'(BUS_WIDTH);
                miss   <= 1'b1;
            end else if (hit) begin
                done_q <= 1'b1;
                len    <= cnt_q;
                miss   <= 1'b0;
            end else begin
                sh_q  <= sh_q >> 1;
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end
endmodule

// File: rtl/huff_len_scan.sv
// Multi-lane Huffman code-length scanner: accepts a set of lane words,
// scans all lanes in parallel, and presents per-lane length/miss results.
//
// state | meaning
// IDLE  | waiting for an input word set
// SCAN  | lanes shifting and comparing against the end symbol
// DONE  | results valid, held until consumed
module huff_len_scan import huff_pkg::*; #(
    parameter int BUS_WIDTH = 64,
    parameter int LANES     = 4,
    parameter int END_WIDTH = 6
) (
    input  logic            clk,
    input  logic            rst,
    huff_len_scan_if.slave  bus
);
    localparam int LEN_W = len_w(BUS_WIDTH);

    state_t               state_q;
    state_t               state_d;
    logic [END_WIDTH-1:0] sym_q;
    logic [BUS_WIDTH-1:0] sym_ext;
    logic [LANES-1:0]     done_nxt;
    logic                 accept;
    logic                 scan;

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (&done_nxt) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) state_d = bus.in_valid ? ST_SCAN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept   = bus.in_valid && bus.in_ready;
    assign scan     = (state_q == ST_SCAN);
    assign bus.busy = scan;
    assign sym_ext  = BUS_WIDTH'(sym_q);

    // State register and end-symbol capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sym_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) sym_q <= bus.end_sym;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        huff_len_lane #(
            .BUS_WIDTH (BUS_WIDTH),
            .LEN_W     (LEN_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (accept),
            .en_in    (bus.lane_en[k]),
            .word_in  (bus.din[k*BUS_WIDTH +: BUS_WIDTH]),
            .sym      (sym_ext),
            .scan     (scan),
            .done_nxt (done_nxt[k]),
            .len      (bus.len[k*LEN_W +: LEN_W]),
            .miss     (bus.miss[k])
        );
    end
endmodule

// File: tb/tb_huff_len_scan.sv
// Directed self-checking bench for huff_len_scan.
module tb_huff_len_scan;
    import huff_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    int   lat;
    int   seen;

    always #5 clk = ~clk;

    huff_len_scan_if #(.BUS_WIDTH(64), .LANES(4), .END_WIDTH(6)) bus ();

    huff_len_scan #(.BUS_WIDTH(64), .LANES(4), .END_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one input set at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [255:0] d, input logic [3:0] en, input logic [5:0] s);
        bus.din      = d;
        bus.lane_en  = en;
        bus.end_sym  = s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count active edges after the accept until out_valid, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.din       = '0;
        bus.lane_en   = '0;
        bus.end_sym   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_len", bus.len, 0);
        check("rst_miss", bus.miss, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single match at position 5 on every lane.
        send({4{64'h240}}, 4'b1111, END_SYM_DEFAULT);
        check("single_busy", bus.busy, 1);
        check("single_in_ready", bus.in_ready, 0);
        wait_valid(lat);
        check("single_latency", lat, 6);
        check("single_len", bus.len, {7'd5, 7'd5, 7'd5, 7'd5});
        check("single_miss", bus.miss, 4'b0000);
        @(negedge clk);
        check("single_idle_valid", bus.out_valid, 0);
        check("single_idle_ready", bus.in_ready, 1);

        // Mixed lanes with a full-width miss, under backpressure.
        bus.out_ready = 1'b0;
        send({64'hFFFF_FFFF_FFFF_FFFF, 64'h4800, 64'h90, 64'h12}, 4'b1111, END_SYM_DEFAULT);
        bus.din     = {4{64'h12}};
        bus.lane_en = 4'b0000;
        wait_valid(lat);
        check("mixed_latency", lat, 65);
        check("mixed_len", bus.len, {7'd64, 7'd10, 7'd3, 7'd0});
        check("mixed_miss", bus.miss, 4'b1000);
        bus.din      = {4{64'h12}};
        bus.lane_en  = 4'b1111;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_len", bus.len, {7'd64, 7'd10, 7'd3, 7'd0});
            check("stall_miss", bus.miss, 4'b1000);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
        end

        // Release with a new set pending: back-to-back accept.
        bus.din       = {64'h5, 64'h280, 64'h5, 64'h14};
        bus.lane_en   = 4'b0101;
        bus.end_sym   = 6'b000101;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_busy", bus.busy, 1);
        check("b2b_out_valid", bus.out_valid, 0);
        wait_valid(lat);
        check("b2b_latency", lat, 8);
        check("b2b_len", bus.len, {7'd0, 7'd7, 7'd0, 7'd2});
        check("b2b_miss", bus.miss, 4'b0000);
        @(negedge clk);
        check("b2b_idle_valid", bus.out_valid, 0);
        check("b2b_idle_busy", bus.busy, 0);

        // No lanes enabled.
        send({4{64'h12}}, 4'b0000, END_SYM_DEFAULT);
        wait_valid(lat);
        check("none_latency", lat, 1);
        check("none_len", bus.len, 0);
        check("none_miss", bus.miss, 0);
        @(negedge clk);

        // Reset three edges after accept, with in_valid held high.
        send({4{64'h240}}, 4'b1111, END_SYM_DEFAULT);
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_len", bus.len, 0);
        check("midrst_miss", bus.miss, 0);
        @(negedge clk);
        check("rst_prio_busy", bus.busy, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        check("no_stale_result", seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
